// File: rtl/sos_delay_aligner_if.sv
// Sample/measurement bus of the speed-of-sound delay aligner.
// The driver of audio and measurements uses master; the aligner uses slave.
interface sos_delay_aligner_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         step_in;
  logic signed [DATA_WIDTH-1:0] audio_in;
  logic [11:0]                  delay_in;
  logic                         delay_valid_in;
  logic signed [DATA_WIDTH-1:0] audio_out;
  logic                         audio_valid_out;
  logic [11:0]                  cur_delay_out;
  logic [11:0]                  target_delay_out;
  logic                         locked_out;
  logic                         range_err_out;

  modport master (
    output step_in, audio_in, delay_in, delay_valid_in,
    input  audio_out, audio_valid_out, cur_delay_out, target_delay_out,
           locked_out, range_err_out
  );

  modport slave (
    input  step_in, audio_in, delay_in, delay_valid_in,
    output audio_out, audio_valid_out, cur_delay_out, target_delay_out,
           locked_out, range_err_out
  );
endinterface

// File: rtl/sos_delay_aligner.sv
// Delays a 16-bit audio stream by the measured acoustic delay using a circular BRAM buffer.
// Optional macro SOS_DELAY_SLEW_EN: slew cur_delay one sample per step instead of jumping.
module sos_delay_aligner #(
  parameter int DEPTH      = 512,
  parameter int OFFSET     = 0,
  parameter int DATA_WIDTH = 16
) (
  input logic              clk_in,
  input logic              rst_in,
  sos_delay_aligner_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (AW + 1 > 12) ? AW + 1 : 12;
  localparam logic [11:0] MAX_DELAY = 12'(DEPTH - 1);
  localparam logic [11:0] OFFSET_W  = 12'(OFFSET);
  localparam logic [AW:0] FILL_MAX  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {SRC_ZERO, SRC_BYPASS, SRC_RAM} src_t;

`ifdef SOS_DELAY_SLEW_EN
  typedef enum logic [1:0] {BYPASS, SLEW, LOCKED} state_t;
`else
  typedef enum logic [0:0] {BYPASS, LOCKED} state_t;
`endif

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];
  logic signed [DATA_WIDTH-1:0] rd_data_reg;
  logic signed [DATA_WIDTH-1:0] bypass_data_reg;
  src_t                         src_reg;
  logic                         audio_valid_reg;

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   fill_cnt_reg;

  state_t      state_reg, state_next;
  logic [11:0] cur_delay_reg, cur_next;
  logic [11:0] target_reg, target_next;
  logic        range_err_reg, range_err_next;
  logic        locked_reg, locked_next;
`ifndef SOS_DELAY_SLEW_EN
  logic        pend_reg, pend_next;
`endif

  logic [11:0] adj;
  logic        meas_clamp;
  logic [11:0] meas_target;

  // Measurement conditioning: remove system latency, then clamp to the buffer span.
  always_comb begin
    adj         = (bus.delay_in > OFFSET_W) ? (bus.delay_in - OFFSET_W) : 12'd0;
    meas_clamp  = (adj > MAX_DELAY);
    meas_target = meas_clamp ? MAX_DELAY : adj;
  end

  assign rd_addr = wr_ptr_reg - cur_delay_reg[AW-1:0];

  // A step always acts on the old target; a same-cycle measurement only affects later steps.
  always_comb begin
    cur_next       = cur_delay_reg;
    state_next     = state_reg;
    target_next    = target_reg;
    range_err_next = range_err_reg;
`ifdef SOS_DELAY_SLEW_EN
    if (bus.step_in && (state_reg == SLEW)) begin
      if (cur_delay_reg < target_reg) begin
        cur_next = cur_delay_reg + 12'd1;
      end else if (cur_delay_reg > target_reg) begin
        cur_next = cur_delay_reg - 12'd1;
      end
      if (cur_next == target_reg) begin
        state_next = LOCKED;
      end
    end
    if (bus.delay_valid_in) begin
      target_next    = meas_target;
      range_err_next = meas_clamp;
      if ((state_next == BYPASS) || (meas_target != cur_next)) begin
        state_next = SLEW;
      end
    end
    locked_next = (state_next == LOCKED);
`else
    pend_next = pend_reg;
    if (bus.step_in && pend_reg) begin
      cur_next   = target_reg;
      state_next = LOCKED;
      pend_next  = 1'b0;
    end
    if (bus.delay_valid_in) begin
      target_next    = meas_target;
      range_err_next = meas_clamp;
      if ((state_next == BYPASS) || (meas_target != cur_next)) begin
        pend_next = 1'b1;
      end
    end
    locked_next = (state_next == LOCKED) && !pend_next;
`endif
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg     <= BYPASS;
      cur_delay_reg <= '0;
      target_reg    <= '0;
      range_err_reg <= 1'b0;
      locked_reg    <= 1'b0;
`ifndef SOS_DELAY_SLEW_EN
      pend_reg      <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cur_delay_reg <= cur_next;
      target_reg    <= target_next;
      range_err_reg <= range_err_next;
      locked_reg    <= locked_next;
`ifndef SOS_DELAY_SLEW_EN
      pend_reg      <= pend_next;
`endif
    end
  end

  // Buffer RAM: no reset so it maps onto a simple dual-port block RAM.
  always_ff @(posedge clk_in) begin
    if (bus.step_in) begin
      mem[wr_ptr_reg] <= bus.audio_in;
      rd_data_reg     <= mem[rd_addr];
    end
  end

  // Zero-delay reads bypass the RAM, so read-during-write ordering never matters.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_reg      <= '0;
      fill_cnt_reg    <= '0;
      bypass_data_reg <= '0;
      src_reg         <= SRC_ZERO;
      audio_valid_reg <= 1'b0;
    end else begin
      audio_valid_reg <= bus.step_in;
      if (bus.step_in) begin
        wr_ptr_reg      <= wr_ptr_reg + AW'(1);
        bypass_data_reg <= bus.audio_in;
        if (fill_cnt_reg != FILL_MAX) begin
          fill_cnt_reg <= fill_cnt_reg + (AW + 1)'(1);
        end
        if (cur_delay_reg == 12'd0) begin
          src_reg <= SRC_BYPASS;
        end else if (CW'(cur_delay_reg) > CW'(fill_cnt_reg)) begin
          src_reg <= SRC_ZERO;
        end else begin
          src_reg <= SRC_RAM;
        end
      end
    end
  end

  always_comb begin
    case (src_reg)
      SRC_BYPASS: bus.audio_out = bypass_data_reg;
      SRC_RAM:    bus.audio_out = rd_data_reg;
      default:    bus.audio_out = '0;
    endcase
  end

  assign bus.audio_valid_out  = audio_valid_reg;
  assign bus.cur_delay_out    = cur_delay_reg;
  assign bus.target_delay_out = target_reg;
  assign bus.locked_out       = locked_reg;
  assign bus.range_err_out    = range_err_reg;

endmodule

// File: tb/tb_sos_delay_aligner.sv
// Directed scoreboard bench for sos_delay_aligner (DEPTH=512, OFFSET=3); follows SOS_DELAY_SLEW_EN.
module tb_sos_delay_aligner;

  localparam int DEPTH  = 512;
  localparam int OFFSET = 3;
  localparam int DW     = 16;
  localparam int M_BYP  = 0;
  localparam int M_SLEW = 1;
  localparam int M_LOCK = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sos_delay_aligner_if #(.DATA_WIDTH(DW)) bus ();

  sos_delay_aligner #(
    .DEPTH(DEPTH),
    .OFFSET(OFFSET),
    .DATA_WIDTH(DW)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] hist [0:4095];
  int nsteps;
  int m_cur, m_tgt, m_state;
  bit m_pend, m_err;
  logic [15:0] last_out;
  int k;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = 0; m_tgt = 0; m_state = M_BYP; m_pend = 0; m_err = 0;
    nsteps = 0; last_out = '0;
  endtask

  task automatic model_step();
`ifdef SOS_DELAY_SLEW_EN
    if (m_state == M_SLEW) begin
      if (m_cur < m_tgt) m_cur++;
      else if (m_cur > m_tgt) m_cur--;
      if (m_cur == m_tgt) m_state = M_LOCK;
    end
`else
    if (m_pend) begin
      m_cur = m_tgt; m_state = M_LOCK; m_pend = 0;
    end
`endif
  endtask

  task automatic model_measure(input int d);
    int adj;
    adj   = (d > OFFSET) ? d - OFFSET : 0;
    m_err = (adj > DEPTH - 1);
    m_tgt = m_err ? DEPTH - 1 : adj;
`ifdef SOS_DELAY_SLEW_EN
    if (m_state == M_BYP || m_tgt != m_cur) m_state = M_SLEW;
`else
    if (m_state == M_BYP || m_tgt != m_cur) m_pend = 1;
`endif
  endtask

  task automatic check_status(input string tag);
    check({tag, ".cur"},    32'(bus.cur_delay_out),    32'(m_cur));
    check({tag, ".target"}, 32'(bus.target_delay_out), 32'(m_tgt));
    check({tag, ".locked"}, 32'(bus.locked_out),       32'((m_state == M_LOCK) && !m_pend));
    check({tag, ".rangeerr"}, 32'(bus.range_err_out),  32'(m_err));
  endtask

  task automatic do_step(input logic [15:0] data, input bit dv, input int din);
    logic [15:0] e;
    logic [15:0] a;
    logic [31:0] dw;
    dw = 32'(din);
    @(negedge clk);
    bus.step_in = 1'b1;
    bus.audio_in = data;
    bus.delay_valid_in = dv;
    bus.delay_in = dw[11:0];
    if (m_cur == 0) e = data;
    else if (m_cur > nsteps) e = '0;
    else e = hist[nsteps - m_cur];
    exp_q.push_back(e);
    hist[nsteps] = data;
    nsteps++;
    model_step();
    if (dv) model_measure(din);
    @(posedge clk);
    #1;
    bus.step_in = 1'b0;
    bus.delay_valid_in = 1'b0;
    check("valid", 32'(bus.audio_valid_out), 32'd1);
    a = bus.audio_out;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("audio", {16'd0, a}, {16'd0, e});
      last_out = e;
    end
    check_status("step");
    @(posedge clk);
    #1;
    check("valid_idle", 32'(bus.audio_valid_out), 32'd0);
    a = bus.audio_out;
    check("audio_hold", {16'd0, a}, {16'd0, last_out});
  endtask

  task automatic ramp(input int n);
    for (int i = 0; i < n; i++) begin
      k++;
      do_step(16'(k), 1'b0, 0);
    end
  endtask

  task automatic measure(input int d);
    @(negedge clk);
    bus.delay_valid_in = 1'b1;
    bus.delay_in = 12'(d);
    model_measure(d);
    @(posedge clk);
    #1;
    bus.delay_valid_in = 1'b0;
    check_status("meas");
  endtask

  task automatic check_all_zero(input string tag);
    logic [15:0] a;
    a = bus.audio_out;
    check({tag, ".audio"},  {16'd0, a}, 32'd0);
    check({tag, ".valid"},  32'(bus.audio_valid_out),  32'd0);
    check({tag, ".cur"},    32'(bus.cur_delay_out),    32'd0);
    check({tag, ".target"}, 32'(bus.target_delay_out), 32'd0);
    check({tag, ".locked"}, 32'(bus.locked_out),       32'd0);
    check({tag, ".rangeerr"}, 32'(bus.range_err_out),  32'd0);
  endtask

  initial begin
    bus.step_in = 1'b0;
    bus.audio_in = '0;
    bus.delay_in = '0;
    bus.delay_valid_in = 1'b0;
    k = 0;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Passthrough with no measurement
    ramp(10);

    // delay_in=8 with OFFSET=3 -> target 5
    measure(8);
    ramp(20);
    check("lock5.cur", 32'(bus.cur_delay_out), 32'd5);
    check("lock5.locked", 32'(bus.locked_out), 32'd1);

    // Out-of-range clamp, then recovery
    measure(700);
    check("clamp.target", 32'(bus.target_delay_out), 32'd511);
    check("clamp.err", 32'(bus.range_err_out), 32'd1);
    measure(103);
    check("unclamp.target", 32'(bus.target_delay_out), 32'd100);
    check("unclamp.err", 32'(bus.range_err_out), 32'd0);
    ramp(120);

    // Offset saturates to zero
    measure(2);
    ramp(110);
    check("zero.cur", 32'(bus.cur_delay_out), 32'd0);
    check("zero.locked", 32'(bus.locked_out), 32'd1);

    // Lock at 20, then retarget to 18 on a step cycle
    measure(23);
    ramp(30);
    check("lock20.cur", 32'(bus.cur_delay_out), 32'd20);
    k++;
    do_step(16'(k), 1'b1, 21);
    check("simul.cur", 32'(bus.cur_delay_out), 32'd20);
    check("simul.locked", 32'(bus.locked_out), 32'd0);
    ramp(4);
    check("lock18.cur", 32'(bus.cur_delay_out), 32'd18);
    check("lock18.locked", 32'(bus.locked_out), 32'd1);

    // Long run at 300, then asynchronous reset between edges
    measure(303);
    ramp(1000);
    check("d300.cur", 32'(bus.cur_delay_out), 32'd300);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    ramp(5);
    measure(23);
    ramp(30);

    // Boundary: 514-3=511 is in range; 515 clamps to the same value
    measure(514);
    check("edge.err", 32'(bus.range_err_out), 32'd0);
    measure(515);
    check("edge_clamp.err", 32'(bus.range_err_out), 32'd1);
    ramp(2000);
    check("wrap.cur", 32'(bus.cur_delay_out), 32'd511);
    check("wrap.locked", 32'(bus.locked_out), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
